// File: rtl/sdram_init_param_pkg.sv
// Shared definitions for the SDRAM power-up initialisation sequencer:
// command encodings, FSM state encoding and mode-register field positions.
package sdram_init_param_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_AR  = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam int MODE_BL_LSB  = 0;
  localparam int MODE_BT_BIT  = 3;
  localparam int MODE_CAS_LSB = 4;
  localparam int MODE_WB_BIT  = 9;

  typedef enum logic [3:0] {
    ST_WAIT = 4'd0,
    ST_PRE  = 4'd1,
    ST_TRP  = 4'd2,
    ST_AR   = 4'd3,
    ST_TRFC = 4'd4,
    ST_MRS  = 4'd5,
    ST_TMRD = 4'd6,
    ST_EMRS = 4'd7,
    ST_END  = 4'd8
  } state_t;

  function automatic int max_int(input int a, input int b);
    max_int = (a > b) ? a : b;
  endfunction

  // Low 11 address bits of the MRS word; upper bits are always zero.
  function automatic logic [10:0] mode_word(input logic [2:0] cas, input logic [2:0] bl,
                                            input logic bt, input logic wb);
    logic [10:0] w;
    w = 11'd0;
    w[MODE_BL_LSB +: 3]  = bl;
    w[MODE_BT_BIT]       = bt;
    w[MODE_CAS_LSB +: 3] = cas;
    w[MODE_WB_BIT]       = wb;
    mode_word = w;
  endfunction

endpackage

// File: rtl/sdram_init_param_if.sv
// Bus between the init sequencer (master) and the SDRAM controller side (slave).
interface sdram_init_param_if #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2
);
  logic              init_req;
  logic [3:0]        init_cmd;
  logic [BA_W-1:0]   init_bank;
  logic [ADDR_W-1:0] init_addr;
  logic              init_busy;
  logic              init_end;

  modport master (
    input  init_req,
    output init_cmd,
    output init_bank,
    output init_addr,
    output init_busy,
    output init_end
  );

  modport slave (
    output init_req,
    input  init_cmd,
    input  init_bank,
    input  init_addr,
    input  init_busy,
    input  init_end
  );
endinterface

// File: rtl/sdram_init_param.sv
// Parametrised SDRAM power-up init sequencer: WAIT -> PRE -> N x AR -> MRS -> optional EMRS -> END,
// with re-initialisation (skipping the power-up wait) on request once finished.
module sdram_init_param
  import sdram_init_param_pkg::*;
#(
  parameter int                ADDR_W     = 13,
  parameter int                BA_W       = 2,
  parameter int                T_POWER_UP = 20000,
  parameter int                T_RP       = 2,
  parameter int                T_RFC      = 7,
  parameter int                T_MRD      = 3,
  parameter int                AR_NUM     = 8,
  parameter int                CAS_LAT    = 3,
  parameter logic [2:0]        BURST_LEN  = 3'b111,
  parameter int                BURST_TYPE = 0,
  parameter int                WR_BURST   = 0,
  parameter int                EMRS_EN    = 0,
  parameter logic [ADDR_W-1:0] EMRS_VAL   = '0
) (
  input logic                init_clk,
  input logic                init_rst,
  sdram_init_param_if.master bus
);

  localparam int T_MAX = max_int(max_int(T_POWER_UP, T_RP), max_int(T_RFC, T_MRD));
  localparam int CNT_W = $clog2(T_MAX) + 1;

  localparam logic [ADDR_W-1:0] MRS_ADDR =
    ADDR_W'(mode_word(3'(CAS_LAT), BURST_LEN, 1'(BURST_TYPE), 1'(WR_BURST)));
  localparam logic [BA_W-1:0] EMRS_BANK = {1'b1, {(BA_W-1){1'b0}}};

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       ar_cnt_r;
  logic             emrs_done_r;

  logic             wait_st_s;
  logic             wait_done_s;
  logic             ar_inc_s;
  logic             emrs_set_s;
  logic             reinit_s;

  // Terminal count of whichever timed wait state is active
  always_comb begin
    wait_st_s   = 1'b1;
    wait_done_s = 1'b0;
    case (state_r)
      ST_WAIT: wait_done_s = (cnt_r == CNT_W'(T_POWER_UP - 1));
      ST_TRP:  wait_done_s = (cnt_r == CNT_W'(T_RP - 1));
      ST_TRFC: wait_done_s = (cnt_r == CNT_W'(T_RFC - 1));
      ST_TMRD: wait_done_s = (cnt_r == CNT_W'(T_MRD - 1));
      default: wait_st_s   = 1'b0;
    endcase
  end

  // Next-state selection and counter control strobes
  always_comb begin
    state_s    = state_r;
    ar_inc_s   = 1'b0;
    emrs_set_s = 1'b0;
    reinit_s   = 1'b0;
    case (state_r)
      ST_WAIT: begin
        if (wait_done_s) state_s = ST_PRE;
        else             state_s = ST_WAIT;
      end
      ST_PRE: state_s = ST_TRP;
      ST_TRP: begin
        if (wait_done_s) state_s = ST_AR;
        else             state_s = ST_TRP;
      end
      ST_AR: begin
        ar_inc_s = 1'b1;
        state_s  = ST_TRFC;
      end
      ST_TRFC: begin
        // ar_cnt_r already counts the AR just issued
        if (!wait_done_s)                state_s = ST_TRFC;
        else if (ar_cnt_r < 8'(AR_NUM))  state_s = ST_AR;
        else                             state_s = ST_MRS;
      end
      ST_MRS: state_s = ST_TMRD;
      ST_TMRD: begin
        if (!wait_done_s)                          state_s = ST_TMRD;
        else if ((EMRS_EN != 0) && !emrs_done_r)   state_s = ST_EMRS;
        else                                       state_s = ST_END;
      end
      ST_EMRS: begin
        emrs_set_s = 1'b1;
        state_s    = ST_TMRD;
      end
      ST_END: begin
        if (bus.init_req) begin
          reinit_s = 1'b1;
          state_s  = ST_PRE;
        end else begin
          state_s  = ST_END;
        end
      end
      default: state_s = ST_WAIT;
    endcase
  end

  // State register, per-state cycle counter, AR counter and EMRS-issued flag
  always_ff @(posedge init_clk) begin
    if (init_rst) begin
      state_r     <= ST_WAIT;
      cnt_r       <= '0;
      ar_cnt_r    <= 8'd0;
      emrs_done_r <= 1'b0;
    end else begin
      state_r <= state_s;

      if (state_s != state_r) cnt_r <= '0;
      else if (wait_st_s)     cnt_r <= cnt_r + CNT_W'(1);
      else                    cnt_r <= cnt_r;

      if (reinit_s)      ar_cnt_r <= 8'd0;
      else if (ar_inc_s) ar_cnt_r <= ar_cnt_r + 8'd1;
      else               ar_cnt_r <= ar_cnt_r;

      if (reinit_s)        emrs_done_r <= 1'b0;
      else if (emrs_set_s) emrs_done_r <= 1'b1;
      else                 emrs_done_r <= emrs_done_r;
    end
  end

  // Bus outputs decoded from the registered state only
  always_comb begin
    bus.init_cmd  = CMD_NOP;
    bus.init_bank = '0;
    bus.init_addr = '0;
    bus.init_end  = 1'b0;
    bus.init_busy = 1'b1;
    case (state_r)
      ST_PRE: begin
        bus.init_cmd  = CMD_PRE;
        bus.init_bank = '1;
        bus.init_addr = '1;
      end
      ST_AR:  bus.init_cmd = CMD_AR;
      ST_MRS: begin
        bus.init_cmd  = CMD_MRS;
        bus.init_addr = MRS_ADDR;
      end
      ST_EMRS: begin
        bus.init_cmd  = CMD_MRS;
        bus.init_bank = EMRS_BANK;
        bus.init_addr = EMRS_VAL;
      end
      ST_END: begin
        bus.init_end  = 1'b1;
        bus.init_busy = 1'b0;
      end
      default: bus.init_cmd = CMD_NOP;
    endcase
  end

endmodule

// File: tb/tb_sdram_init_param.sv
// Bench for sdram_init_param: four configurations checked every cycle against a
// timeline model computed from the command schedule, plus hand-computed pin values.
module tb_sdram_init_param;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AR   = 4'b0001;
  localparam logic [3:0] MRSC = 4'b0000;

  localparam int TPU  = 10;
  localparam int TRP  = 2;
  localparam int TRFC = 7;
  localparam int TMRD = 3;
  localparam int CAS  = 3;
  localparam int BL   = 7;
  localparam int BT   = 0;
  localparam int WB   = 0;
  localparam logic [12:0] EMRS_V = 13'h0020;
  localparam int NCYC = 200;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  bank;
    logic [12:0] addr;
    logic        fin;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c, rst_d;
  int checks = 0;
  int failures = 0;

  sdram_init_param_if #(.ADDR_W(13), .BA_W(2)) if_a ();
  sdram_init_param_if #(.ADDR_W(13), .BA_W(2)) if_b ();
  sdram_init_param_if #(.ADDR_W(12), .BA_W(2)) if_c ();
  sdram_init_param_if #(.ADDR_W(13), .BA_W(2)) if_d ();

  sdram_init_param #(.ADDR_W(13), .BA_W(2), .T_POWER_UP(TPU), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD),
    .AR_NUM(8), .CAS_LAT(CAS), .BURST_LEN(3'b111), .BURST_TYPE(BT), .WR_BURST(WB), .EMRS_EN(0),
    .EMRS_VAL(13'h0000)) dut_a (.init_clk(clk), .init_rst(rst_a), .bus(if_a));
  sdram_init_param #(.ADDR_W(13), .BA_W(2), .T_POWER_UP(TPU), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD),
    .AR_NUM(8), .CAS_LAT(CAS), .BURST_LEN(3'b111), .BURST_TYPE(BT), .WR_BURST(WB), .EMRS_EN(1),
    .EMRS_VAL(EMRS_V)) dut_b (.init_clk(clk), .init_rst(rst_b), .bus(if_b));
  sdram_init_param #(.ADDR_W(12), .BA_W(2), .T_POWER_UP(TPU), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD),
    .AR_NUM(2), .CAS_LAT(CAS), .BURST_LEN(3'b111), .BURST_TYPE(BT), .WR_BURST(WB), .EMRS_EN(0),
    .EMRS_VAL(12'h000)) dut_c (.init_clk(clk), .init_rst(rst_c), .bus(if_c));
  sdram_init_param #(.ADDR_W(13), .BA_W(2), .T_POWER_UP(TPU), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD),
    .AR_NUM(8), .CAS_LAT(CAS), .BURST_LEN(3'b111), .BURST_TYPE(BT), .WR_BURST(WB), .EMRS_EN(0),
    .EMRS_VAL(13'h0000)) dut_d (.init_clk(clk), .init_rst(rst_d), .bus(if_d));

  int off [4];
  bit skip [4];
  int last_cyc [4];
  logic [3:0] last_cmd [4];
  bit last_ok [4];
  int arn_cfg [4] = '{8, 8, 2, 8};
  bit emrs_cfg [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int aw_cfg [4] = '{13, 13, 12, 13};

  // Walk the command timeline from the start of the sequence to find what is on the bus at 'o'
  function automatic exp_t expect_at(input int o, input bit sk, input int arn, input bit em, input int aw);
    exp_t e;
    int t;
    logic [12:0] mrs;
    mrs = 13'((WB << 9) | (CAS << 4) | (BT << 3) | BL);
    e = '0;
    e.cmd = NOP;
    t = o;
    if (!sk) begin
      if (t < TPU) return e;
      t -= TPU;
    end
    if (t == 0) begin
      e.cmd = PRE; e.bank = 2'b11; e.addr = 13'((1 << aw) - 1);
      return e;
    end
    t -= 1;
    if (t < TRP) return e;
    t -= TRP;
    if (t < arn * (1 + TRFC)) begin
      if (t % (1 + TRFC) == 0) e.cmd = AR;
      return e;
    end
    t -= arn * (1 + TRFC);
    if (t == 0) begin
      e.cmd = MRSC; e.addr = mrs;
      return e;
    end
    t -= 1;
    if (t < TMRD) return e;
    t -= TMRD;
    if (em) begin
      if (t == 0) begin
        e.cmd = MRSC; e.bank = 2'b10; e.addr = EMRS_V;
        return e;
      end
      t -= 1;
      if (t < TMRD) return e;
      t -= TMRD;
    end
    e.fin = 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input int cyc, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int min_gap(input logic [3:0] cmd);
    if (cmd == PRE) return 1 + TRP;
    if (cmd == AR)  return 1 + TRFC;
    return 1 + TMRD;
  endfunction

  task automatic compare_all(input int c);
    exp_t act [4];
    logic busy [4];
    exp_t e;
    act[0].cmd = if_a.init_cmd; act[0].bank = if_a.init_bank; act[0].addr = if_a.init_addr;
    act[0].fin = if_a.init_end; busy[0] = if_a.init_busy;
    act[1].cmd = if_b.init_cmd; act[1].bank = if_b.init_bank; act[1].addr = if_b.init_addr;
    act[1].fin = if_b.init_end; busy[1] = if_b.init_busy;
    act[2].cmd = if_c.init_cmd; act[2].bank = if_c.init_bank; act[2].addr = {1'b0, if_c.init_addr};
    act[2].fin = if_c.init_end; busy[2] = if_c.init_busy;
    act[3].cmd = if_d.init_cmd; act[3].bank = if_d.init_bank; act[3].addr = if_d.init_addr;
    act[3].fin = if_d.init_end; busy[3] = if_d.init_busy;
    for (int i = 0; i < 4; i++) begin
      e = expect_at(off[i], skip[i], arn_cfg[i], emrs_cfg[i], aw_cfg[i]);
      check($sformatf("dut%0d_cmd", i), c, int'(act[i].cmd), int'(e.cmd));
      check($sformatf("dut%0d_bank", i), c, int'(act[i].bank), int'(e.bank));
      check($sformatf("dut%0d_addr", i), c, int'(act[i].addr), int'(e.addr));
      check($sformatf("dut%0d_end", i), c, int'(act[i].fin), int'(e.fin));
      check($sformatf("dut%0d_busy", i), c, int'(busy[i]), int'(!e.fin));
      if (act[i].cmd != NOP) begin
        if (last_ok[i])
          check($sformatf("dut%0d_gap", i), c, int'((c - last_cyc[i]) >= min_gap(last_cmd[i])), 1);
        last_ok[i] = 1'b1;
        last_cyc[i] = c;
        last_cmd[i] = act[i].cmd;
      end
    end
    // Hand-computed pins for the model itself
    case (c)
      10:  begin check("a_pre_cmd", c, int'(if_a.init_cmd), 32'h2); check("a_pre_bank", c, int'(if_a.init_bank), 3);
             check("a_pre_addr", c, int'(if_a.init_addr), 32'h1FFF); check("c_pre_addr", c, int'(if_c.init_addr), 32'hFFF); end
      13:  check("a_ar0", c, int'(if_a.init_cmd), 32'h1);
      29:  check("c_mrs", c, int'(if_c.init_cmd), 32'h0);
      33:  check("c_end", c, int'(if_c.init_end), 1);
      41:  begin check("d_rst_nop", c, int'(if_d.init_cmd), 32'h7); check("c_repre", c, int'(if_c.init_cmd), 32'h2); end
      51:  check("d_pre_again", c, int'(if_d.init_cmd), 32'h2);
      64:  check("c_end2", c, int'(if_c.init_end), 1);
      69:  check("a_ar7", c, int'(if_a.init_cmd), 32'h1);
      77:  begin check("a_mrs_cmd", c, int'(if_a.init_cmd), 32'h0); check("a_mrs_addr", c, int'(if_a.init_addr), 32'h037); end
      80:  check("a_end_low", c, int'(if_a.init_end), 0);
      81:  begin check("a_end_rise", c, int'(if_a.init_end), 1); check("b_emrs_cmd", c, int'(if_b.init_cmd), 32'h0);
             check("b_emrs_bank", c, int'(if_b.init_bank), 2); check("b_emrs_addr", c, int'(if_b.init_addr), 32'h020); end
      84:  check("b_end_low", c, int'(if_b.init_end), 0);
      85:  check("b_end_rise", c, int'(if_b.init_end), 1);
      91:  check("a_reinit_pre", c, int'(if_a.init_cmd), 32'h2);
      102: check("a_ar_after_ignored_req", c, int'(if_a.init_cmd), 32'h1);
      161: check("a_end2_low", c, int'(if_a.init_end), 0);
      162: check("a_end2_rise", c, int'(if_a.init_end), 1);
      default: ;
    endcase
  endtask

  task automatic advance_model(input bit r, input bit q, input int i);
    exp_t e;
    e = expect_at(off[i], skip[i], arn_cfg[i], emrs_cfg[i], aw_cfg[i]);
    if (r) begin
      off[i] = 0; skip[i] = 1'b0; last_ok[i] = 1'b0;
    end else if (e.fin && q) begin
      off[i] = 0; skip[i] = 1'b1;
    end else if (off[i] < 100000) begin
      off[i] = off[i] + 1;
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    if_a.init_req = 1'b0; if_b.init_req = 1'b0; if_c.init_req = 1'b0; if_d.init_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      off[i] = 0; skip[i] = 1'b0; last_ok[i] = 1'b0; last_cyc[i] = 0; last_cmd[i] = NOP;
    end
    @(posedge clk);
    @(negedge clk);
    check("rst_cmd", -1, int'(if_a.init_cmd), 32'h7);
    check("rst_addr", -1, int'(if_b.init_addr), 0);
    check("rst_end", -1, int'(if_c.init_end), 0);
    check("rst_busy", -1, int'(if_d.init_busy), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    for (int c = 0; c <= NCYC; c++) begin
      @(negedge clk);
      compare_all(c);
      if_a.init_req = (c == 90) || (c == 100);
      if_c.init_req = (c == 5) || (c == 40);
      rst_d = (c == 40);
      @(posedge clk);
      advance_model(rst_a, if_a.init_req, 0);
      advance_model(rst_b, if_b.init_req, 1);
      advance_model(rst_c, if_c.init_req, 2);
      advance_model(rst_d, if_d.init_req, 3);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
